// File: rtl/reg_file_pkg.sv
// Shared widths, constants and types for the demultiplexed-write register file.
package reg_file_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned WR_COUNT_W = 16;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [ADDR_W-1:0]     reg_addr_t;
    typedef logic [WR_COUNT_W-1:0] wr_count_t;

endpackage

// File: rtl/decoder_5_to_32.sv
// Enable-gated 5-to-32 one-hot decoder; the demux counterpart of the datapath mux trees.
module decoder_5_to_32
    import reg_file_pkg::*;
(
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NREGS-1:0]  onehot
);

    // A low enable masks every line, so an unknown address cannot raise one.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = en && (addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/reg_file_demux_write.sv
// 32x32 register file: one decoded write port, two combinational read ports, r0 hardwired to zero.
module reg_file_demux_write
    import reg_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [ADDR_W-1:0]     raddr1,
    input  logic [ADDR_W-1:0]     raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    output logic [WR_COUNT_W-1:0] wr_count
);

    logic [NREGS-1:0]  we_dec;
    word_t             regs_q [1:NREGS-1];
    word_t             regs_d [1:NREGS-1];
    word_t             rd_view [NREGS];
    wr_count_t         wr_count_q;
    wr_count_t         wr_count_d;
    logic              commit;

    decoder_5_to_32 u_wr_dec (
        .en     (we),
        .addr   (waddr),
        .onehot (we_dec)
    );

    // Line 0 of the decode is the discarded r0 write; it never counts.
    assign commit = we && !we_dec[ZERO_REG];

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NREGS; i++) begin
            if (we_dec[i]) begin
                regs_d[i] = wdata;
            end
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (commit && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + WR_COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Read view with entry 0 tied to zero; no bypass from the write port.
    always_comb begin
        rd_view[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            rd_view[i] = regs_q[i];
        end
    end

    assign rdata1   = rd_view[raddr1];
    assign rdata2   = rd_view[raddr2];
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_demux_write.sv
// Directed self-checking bench for reg_file_demux_write.
module tb_reg_file_demux_write;
    import reg_file_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [ADDR_W-1:0]     raddr1;
    logic [ADDR_W-1:0]     raddr2;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic [WR_COUNT_W-1:0] wr_count;

    int total;
    int bad;

    reg_file_demux_write dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one write across a single rising edge; sample point is #1 after the edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        raddr1 = 5'd5;
        raddr2 = REG_RA;
        #1;
        total++;
        if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h exp=%h", rdata1, 32'h0); end
        total++;
        if (rdata2 !== 32'h0) begin bad++; $display("FAIL reset_rdata2 got=%h exp=%h", rdata2, 32'h0); end
        total++;
        if (wr_count !== 16'h0) begin bad++; $display("FAIL reset_wr_count got=%h exp=%h", wr_count, 16'h0); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_basic;
        do_write(5'd5, 32'hDEADBEEF);
        raddr1 = 5'd5;
        raddr2 = 5'd4;
        #1;
        total++;
        if (rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL wr5_rdata1 got=%h exp=%h", rdata1, 32'hDEADBEEF); end
        total++;
        if (rdata2 !== 32'h0) begin bad++; $display("FAIL wr5_reg4 got=%h exp=%h", rdata2, 32'h0); end
        raddr2 = 5'd6;
        #1;
        total++;
        if (rdata2 !== 32'h0) begin bad++; $display("FAIL wr5_reg6 got=%h exp=%h", rdata2, 32'h0); end
        total++;
        if (wr_count !== 16'd1) begin bad++; $display("FAIL wr5_count got=%h exp=%h", wr_count, 16'd1); end
    endtask

    task automatic test_write_zero;
        do_write(ZERO_REG, 32'hFFFFFFFF);
        raddr1 = ZERO_REG;
        #1;
        total++;
        if (rdata1 !== 32'h0) begin bad++; $display("FAIL r0_read got=%h exp=%h", rdata1, 32'h0); end
        total++;
        if (wr_count !== 16'd1) begin bad++; $display("FAIL r0_count got=%h exp=%h", wr_count, 16'd1); end
    endtask

    task automatic test_read_during_write;
        do_write(5'd7, 32'h11);
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd7;
        wdata  = 32'h22;
        raddr2 = 5'd7;
        #1;
        total++;
        if (rdata2 !== 32'h11) begin bad++; $display("FAIL rdw_before got=%h exp=%h", rdata2, 32'h11); end
        @(posedge clk);
        #1;
        we = 1'b0;
        total++;
        if (rdata2 !== 32'h22) begin bad++; $display("FAIL rdw_after got=%h exp=%h", rdata2, 32'h22); end
        total++;
        if (wr_count !== 16'd3) begin bad++; $display("FAIL rdw_count got=%h exp=%h", wr_count, 16'd3); end
    endtask

    task automatic test_we_low;
        we    = 1'b0;
        wdata = 32'hA5A5A5A5;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            waddr = (k % 3 == 2) ? 'x : ((k % 2 == 0) ? 5'd3 : 5'd5);
        end
        @(negedge clk);
        raddr1 = 5'd3;
        raddr2 = 5'd5;
        #1;
        total++;
        if (rdata1 !== 32'h0) begin bad++; $display("FAIL welow_reg3 got=%h exp=%h", rdata1, 32'h0); end
        total++;
        if (rdata2 !== 32'hDEADBEEF) begin bad++; $display("FAIL welow_reg5 got=%h exp=%h", rdata2, 32'hDEADBEEF); end
        raddr1 = 5'd7;
        #1;
        total++;
        if (rdata1 !== 32'h22) begin bad++; $display("FAIL welow_reg7 got=%h exp=%h", rdata1, 32'h22); end
        total++;
        if (wr_count !== 16'd3) begin bad++; $display("FAIL welow_count got=%h exp=%h", wr_count, 16'd3); end
        waddr = 5'd0;
    endtask

    task automatic test_all_regs;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'h1000_0000 + 32'(i));
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            e1 = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
            e2 = (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i);
            #1;
            total++;
            if (rdata1 !== e1) begin bad++; $display("FAIL all_p1[%0d] got=%h exp=%h", i, rdata1, e1); end
            total++;
            if (rdata2 !== e2) begin bad++; $display("FAIL all_p2[%0d] got=%h exp=%h", 31 - i, rdata2, e2); end
        end
        raddr1 = REG_SP;
        raddr2 = REG_SP;
        #1;
        total++;
        if (rdata1 !== 32'h1000_001D || rdata2 !== 32'h1000_001D) begin
            bad++; $display("FAIL same_addr_sp got1=%h got2=%h exp=%h", rdata1, rdata2, 32'h1000_001D);
        end
        total++;
        if (wr_count !== 16'd31) begin bad++; $display("FAIL all_count got=%h exp=%h", wr_count, 16'd31); end
    endtask

    task automatic test_saturate;
        @(negedge clk);
        force dut.wr_count_q = 16'hFFFE;
        #1;
        release dut.wr_count_q;
        do_write(5'd3, 32'hC0DE_0001);
        total++;
        if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL sat_first got=%h exp=%h", wr_count, 16'hFFFF); end
        do_write(5'd3, 32'hC0DE_0002);
        do_write(5'd3, 32'hC0DE_0003);
        raddr1 = 5'd3;
        #1;
        total++;
        if (wr_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=%h", wr_count, 16'hFFFF); end
        total++;
        if (rdata1 !== 32'hC0DE_0003) begin bad++; $display("FAIL sat_reg3 got=%h exp=%h", rdata1, 32'hC0DE_0003); end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        raddr1 = REG_RA;
        raddr2 = 5'd3;
        #2;
        total++;
        if (rdata1 !== 32'h1000_001F) begin bad++; $display("FAIL pre_rst_ra got=%h exp=%h", rdata1, 32'h1000_001F); end
        reset = 1'b1;
        #1;
        total++;
        if (rdata1 !== 32'h0) begin bad++; $display("FAIL midrst_rdata1 got=%h exp=%h", rdata1, 32'h0); end
        total++;
        if (rdata2 !== 32'h0) begin bad++; $display("FAIL midrst_rdata2 got=%h exp=%h", rdata2, 32'h0); end
        total++;
        if (wr_count !== 16'h0) begin bad++; $display("FAIL midrst_count got=%h exp=%h", wr_count, 16'h0); end
        we     = 1'b1;
        waddr  = 5'd9;
        wdata  = 32'h9999_9999;
        raddr1 = 5'd9;
        @(posedge clk);
        #1;
        total++;
        if (rdata1 !== 32'h0) begin bad++; $display("FAIL rst_override got=%h exp=%h", rdata1, 32'h0); end
        total++;
        if (wr_count !== 16'h0) begin bad++; $display("FAIL rst_override_count got=%h exp=%h", wr_count, 16'h0); end
        @(negedge clk);
        we    = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr1 = '0;
        raddr2 = '0;
        test_reset();
        test_write_basic();
        test_write_zero();
        test_read_during_write();
        test_we_low();
        test_all_regs();
        test_saturate();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
